video_frame_bank: RTL
=====================

VIDEO_FRAME_BANK -- requirements
Module: video_frame_bank

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 32: raster pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 24: raster lines per frame.
REQ-003 SHALL have parameter SCALE, default 4: integer upscale factor; X_WIDTH=SCREEN_WIDTH/SCALE, Y_HEIGHT=SCREEN_HEIGHT/SCALE, DEPTH=X_WIDTH*Y_HEIGHT.
REQ-004 SHALL have parameter BPP, default 1: bits per stored pixel, range 1-8.
REQ-005 SHALL have port CLK_40  input  1  sole clock, rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port video_bank_we  input  1  write enable for the serial fill path.
REQ-008 SHALL have port SPI_clk_en  input  1  one-cycle strobe qualifying MISO.
REQ-009 SHALL have port MISO  input  1  serial pixel data, MSB first per pixel.
REQ-010 SHALL have port read_pixel_clk_en  input  1  one-cycle strobe advancing the raster.
REQ-011 SHALL have port pixel_data_out  output  BPP  registered pixel for the current raster position.
REQ-012 SHALL have port frame_end  output  1  one-cycle pulse on the last raster pixel.
REQ-013 SHALL have port bank_sel  output  1  bank currently being read; the other bank is written.
REQ-014 SHALL have port write_full  output  1  high while the write bank holds a complete frame awaiting swap.
REQ-015 SHALL have port overrun  output  1  one-cycle pulse when a pixel is dropped.

Function
REQ-016 SHALL hold two banks of DEPTH x BPP storage; bank bank_sel is read, bank ~bank_sel is written.
REQ-017 SHALL, on cycles with video_bank_we=1 and SPI_clk_en=1, shift MISO into a BPP-bit shift register; the BPPth bit completes a pixel.
REQ-018 SHALL, in write state FILL, store a completed pixel at wr_addr of the write bank and increment wr_addr; the pixel at wr_addr=DEPTH-1 moves the state to FULL (write_full=1).
REQ-019 SHALL, in state FULL, discard completed pixels, leave wr_addr unchanged and pulse overrun for that cycle.
REQ-020 SHALL retain partial shift-register contents and bit count while video_bank_we=0.
REQ-021 SHALL maintain raster counters x (0..SCREEN_WIDTH-1) and y (0..SCREEN_HEIGHT-1), advanced only on read_pixel_clk_en; x wraps to 0 and increments y; y wraps to 0 after SCREEN_HEIGHT-1.
REQ-022 SHALL, on read_pixel_clk_en, register pixel_data_out = read bank[(y/SCALE)*X_WIDTH + x/SCALE] for the current (x,y), latency 1 cycle; otherwise hold.
REQ-023 SHALL pulse frame_end in the cycle after read_pixel_clk_en at x=SCREEN_WIDTH-1, y=SCREEN_HEIGHT-1.
REQ-024 SHALL, on frame_end, if write state is FULL: toggle bank_sel, clear wr_addr, return to FILL; otherwise keep bank_sel (frame repeats).
REQ-025 SHALL treat a final pixel completing in the same cycle as frame_end as FULL, so the swap occurs.
REQ-026 SHALL, when an overrun pixel and a swap coincide, drop that pixel and pulse overrun.

Reset
REQ-027 SHALL, on reset_n=0, asynchronously clear bank_sel, x, y, wr_addr, shift register, bit count, pixel_data_out, frame_end, overrun; write state FILL, write_full=0.
REQ-028 SHALL NOT reset bank storage contents.

Configuration
REQ-029 SHALL, with VIDEO_REPEAT_COUNT_EN defined, add output repeat_count (16 bits, reset 0) incrementing on each frame_end without a swap, saturating at 16'hFFFF.
REQ-030 SHALL, without VIDEO_REPEAT_COUNT_EN, omit repeat_count and its counter entirely.

Verification (defaults: 32x24, SCALE 4, BPP 1, DEPTH 48)
REQ-031 SHALL verify fill: 48 strobed MISO=1 bits -> write_full=1; next frame_end -> bank_sel=1, then all 768 pixels read =1.
REQ-032 SHALL verify scaling: pixel k = k%2 written -> after swap, pixel_data_out at (x,y) = (x/4)%2 for every line.
REQ-033 SHALL verify underrun: no writes for 3 frames -> bank_sel stays 0, repeat_count=3 (macro on).
REQ-034 SHALL verify overrun: 60 bits with no frame_end -> wr_addr stays 47, overrun pulses 12 times.
REQ-035 SHALL verify coincidence: 48th bit completes in frame_end cycle -> swap occurs, write_full=0 next cycle.
REQ-036 SHALL verify reset mid-fill: reset_n low after 20 bits -> wr_addr=0, bank_sel=0, outputs 0; refill of 48 bits swaps normally.

Source files
------------

// File: rtl/video_frame_bank.sv
// video_frame_bank: double-buffered, upscaled frame store filled serially and read in raster order (VIDEO_REPEAT_COUNT_EN adds repeat_count)
module video_frame_bank #(
  parameter int SCREEN_WIDTH  = 32,
  parameter int SCREEN_HEIGHT = 24,
  parameter int SCALE         = 4,
  parameter int BPP           = 1
) (
  input  logic           CLK_40,
  input  logic           reset_n,
  input  logic           video_bank_we,
  input  logic           SPI_clk_en,
  input  logic           MISO,
  input  logic           read_pixel_clk_en,
  output logic [BPP-1:0] pixel_data_out,
  output logic           frame_end,
  output logic           bank_sel,
  output logic           write_full,
`ifdef VIDEO_REPEAT_COUNT_EN
  output logic [15:0]    repeat_count,
`endif
  output logic           overrun
);
  localparam int X_WIDTH  = SCREEN_WIDTH / SCALE;
  localparam int Y_HEIGHT = SCREEN_HEIGHT / SCALE;
  localparam int DEPTH    = X_WIDTH * Y_HEIGHT;
  localparam int AW       = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int XW       = SCREEN_WIDTH > 1 ? $clog2(SCREEN_WIDTH) : 1;
  localparam int YW       = SCREEN_HEIGHT > 1 ? $clog2(SCREEN_HEIGHT) : 1;
  localparam int CW       = BPP > 1 ? $clog2(BPP) : 1;
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] FULL = 1'b1;

  logic [BPP-1:0] mem [2][DEPTH];
  logic [0:0]     state_q, state_d;
  logic           bank_q, bank_d;
  logic [AW-1:0]  wr_addr_q, wr_addr_d;
  logic [BPP-1:0] sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic [BPP-1:0] pix_q, pix_d;
  logic           fe_q, fe_d;
  logic           ov_q, ov_d;
  logic           strobe, done, fill_wr, last_wr, swap, x_last, y_last;
  logic [BPP-1:0] pix_in;
  logic [AW-1:0]  raddr;

  assign pixel_data_out = pix_q;
  assign frame_end      = fe_q;
  assign bank_sel       = bank_q;
  assign write_full     = state_q == FULL;
  assign overrun        = ov_q;

  // Serial assembly, fill/full handshake with the bank swap, and raster read-out
  always_comb begin
    strobe    = video_bank_we && SPI_clk_en;
    pix_in    = BPP'({sr_q, MISO});
    done      = strobe && cnt_q == CW'(BPP - 1);
    fill_wr   = done && state_q == FILL;
    last_wr   = fill_wr && wr_addr_q == AW'(DEPTH - 1);
    swap      = fe_q && (state_q == FULL || last_wr);
    sr_d      = strobe ? pix_in : sr_q;
    cnt_d     = strobe ? (done ? '0 : cnt_q + CW'(1)) : cnt_q;
    ov_d      = done && state_q == FULL;
    bank_d    = swap ? ~bank_q : bank_q;
    state_d   = swap ? FILL : last_wr ? FULL : state_q;
    wr_addr_d = swap ? '0 : (fill_wr && !last_wr) ? wr_addr_q + AW'(1) : wr_addr_q;
    x_last    = x_q == XW'(SCREEN_WIDTH - 1);
    y_last    = y_q == YW'(SCREEN_HEIGHT - 1);
    raddr     = AW'((int'(y_q) / SCALE) * X_WIDTH + int'(x_q) / SCALE);
    x_d       = read_pixel_clk_en ? (x_last ? '0 : x_q + XW'(1)) : x_q;
    y_d       = (read_pixel_clk_en && x_last) ? (y_last ? '0 : y_q + YW'(1)) : y_q;
    pix_d     = read_pixel_clk_en ? mem[bank_q][raddr] : pix_q;
    fe_d      = read_pixel_clk_en && x_last && y_last;
  end

  // Control and datapath registers; storage is deliberately left out of reset
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= FILL;
      bank_q    <= 1'b0;
      wr_addr_q <= '0;
      sr_q      <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      pix_q     <= '0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      wr_addr_q <= wr_addr_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      pix_q     <= pix_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  // Completed pixels land in the bank not being displayed
  always_ff @(posedge CLK_40) begin
    if (fill_wr) mem[~bank_q][wr_addr_q] <= pix_in;
  end

`ifdef VIDEO_REPEAT_COUNT_EN
  logic [15:0] rep_q, rep_d;

  assign repeat_count = rep_q;

  // Count frames shown again because no new frame was ready, saturating
  always_comb begin
    rep_d = (fe_q && !swap && rep_q != 16'hFFFF) ? rep_q + 16'd1 : rep_q;
  end

  // Repeat counter register
  always_ff @(posedge CLK_40 or negedge reset_n) begin
    if (!reset_n) rep_q <= '0;
    else rep_q <= rep_d;
  end
`endif
endmodule
